// File: rtl/alu_instr_encoder.sv
// Encodes ALU-op requests into RV32I OP/OP-IMM words and writes them sequentially
// into instruction memory through a single registered valid/ready write port.
module alu_instr_encoder #(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [3:0]        i_in_alu_ctrl,
   input  logic              i_in_alu_src,
   input  logic [4:0]        i_in_rd,
   input  logic [4:0]        i_in_rs1,
   input  logic [4:0]        i_in_rs2,
   input  logic [11:0]       i_in_imm,
   input  logic              i_in_last,
   output logic              o_imem_we,
   input  logic              i_imem_ready,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W:0]   o_count
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_e              r_state;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [31:0]         r_wdata;
   logic                r_done;
   logic                r_err;
   logic [ADDR_W:0]     r_count;

   logic [2:0]          w_f3;
   logic [6:0]          w_f7;
   logic                w_legal;
   logic [11:0]         w_imm;
   logic [31:0]         w_word;
   logic                w_in_ready;
   logic                w_accept;
   logic                w_drain;
   logic                w_final;

   always_comb begin
      w_f3    = 3'b000;
      w_f7    = 7'b0000000;
      w_legal = 1'b1;
      case (i_in_alu_ctrl)
         4'b0000: w_f3 = 3'b000;
         4'b0001: begin
            w_f3    = 3'b000;
            w_f7    = 7'b0100000;
            w_legal = !i_in_alu_src;  // no "subi" in RV32I
         end
         4'b0010: w_f3 = 3'b001;
         4'b0011: w_f3 = 3'b010;
         4'b1001: w_f3 = 3'b011;
         4'b0100: w_f3 = 3'b100;
         4'b0101: w_f3 = 3'b101;
         4'b1000: begin
            w_f3 = 3'b101;
            w_f7 = 7'b0100000;
         end
         4'b0110: w_f3 = 3'b110;
         4'b0111: w_f3 = 3'b111;
         default: w_legal = 1'b0;
      endcase

      // Immediate shifts carry funct7 in the upper immediate bits.
      if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
         w_imm = {w_f7, i_in_imm[4:0]};
      end else begin
         w_imm = i_in_imm;
      end

      if (i_in_alu_src) begin
         w_word = {w_imm, i_in_rs1, w_f3, i_in_rd, 7'b0010011};
      end else begin
         w_word = {w_f7, i_in_rs2, i_in_rs1, w_f3, i_in_rd, 7'b0110011};
      end
   end

   assign w_in_ready = (r_state == StRun) && (!r_we || i_imem_ready);
   assign w_accept   = i_in_valid && w_in_ready;
   assign w_drain    = r_we && i_imem_ready;
   assign w_final    = (r_wr_ptr == ADDR_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_we     <= 1'b0;
         r_addr   <= BASE_ADDR;
         r_wr_ptr <= BASE_ADDR;
         r_wdata  <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_drain) begin
            r_we    <= 1'b0;
            r_count <= r_count + COUNT_ONE;
         end

         case (r_state)
            StIdle, StDone: begin
               if (i_start) begin
                  r_state  <= StRun;
                  r_addr   <= BASE_ADDR;
                  r_wr_ptr <= BASE_ADDR;
                  r_count  <= '0;
                  r_err    <= 1'b0;
                  r_done   <= 1'b0;
               end
            end
            StRun: begin
               if (w_accept) begin
                  if (w_legal) begin
                     // Accept overrides a same-cycle drain of the previous word.
                     r_we     <= 1'b1;
                     r_addr   <= r_wr_ptr;
                     r_wdata  <= w_word;
                     r_wr_ptr <= r_wr_ptr + ADDR_ONE;
                     if (i_in_last || w_final) begin
                        r_state <= StDrain;
                     end
                  end else begin
                     r_err <= 1'b1;
                     if (i_in_last) begin
                        r_state <= StDrain;
                     end
                  end
               end
            end
            StDrain: begin
               if (!r_we || i_imem_ready) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_in_ready   = w_in_ready;
   assign o_imem_we    = r_we;
   assign o_imem_addr  = r_addr;
   assign o_imem_wdata = r_wdata;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_count      = r_count;

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed bench for alu_instr_encoder: encodings, stalls, illegal beats,
// restart, async reset mid-stall, and the address-limit path on a 2-bit instance.
module tb_alu_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, in_valid, in_alu_src, in_last, imem_ready;
   logic [3:0]  alu_ctrl;
   logic [4:0]  rd, rs1, rs2;
   logic [11:0] imm;
   logic        in_ready, imem_we, done, err;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  count;

   logic        s_start, s_valid, s_in_ready, s_we, s_done, s_err;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata;
   logic [2:0]  s_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
      .o_in_ready(in_ready), .i_in_alu_ctrl(alu_ctrl), .i_in_alu_src(in_alu_src),
      .i_in_rd(rd), .i_in_rs1(rs1), .i_in_rs2(rs2), .i_in_imm(imm), .i_in_last(in_last),
      .o_imem_we(imem_we), .i_imem_ready(imem_ready), .o_imem_addr(imem_addr),
      .o_imem_wdata(imem_wdata), .o_done(done), .o_err(err), .o_count(count)
   );

   alu_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_small (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_in_valid(s_valid),
      .o_in_ready(s_in_ready), .i_in_alu_ctrl(4'b0000), .i_in_alu_src(1'b0),
      .i_in_rd(5'd3), .i_in_rs1(5'd1), .i_in_rs2(5'd2), .i_in_imm(12'd0), .i_in_last(1'b0),
      .o_imem_we(s_we), .i_imem_ready(1'b1), .o_imem_addr(s_addr),
      .o_imem_wdata(s_wdata), .o_done(s_done), .o_err(s_err), .o_count(s_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [3:0] c, input logic src, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
                      input logic lst);
      in_valid = 1'b1; alu_ctrl = c; in_alu_src = src;
      rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = lst;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_alu_src = 1'b0; in_last = 1'b0;
      imem_ready = 1'b1; alu_ctrl = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      s_start = 1'b0; s_valid = 1'b0;
      #3;
      check("rst_we", {31'd0, imem_we}, 32'd0);
      check("rst_addr", {24'd0, imem_addr}, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_count", {23'd0, count}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      rst_n = 1'b1;
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);

      start = 1'b1;
      step();
      start = 1'b0;
      req(4'b0000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);    // add x3,x1,x2
      #1 check("run_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("add_we", {31'd0, imem_we}, 32'd1);
      check("add_word", imem_wdata, 32'h002081B3);
      check("add_addr", {24'd0, imem_addr}, 32'd0);
      req(4'b0001, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);    // sub x3,x1,x2
      step();
      check("sub_word", imem_wdata, 32'h402081B3);
      check("sub_addr", {24'd0, imem_addr}, 32'd1);
      check("count_1", {23'd0, count}, 32'd1);
      req(4'b0000, 1'b1, 5'd5, 5'd0, 5'd0, 12'hFFF, 1'b0);  // addi x5,x0,-1
      step();
      check("addi_word", imem_wdata, 32'hFFF00293);
      check("addi_addr", {24'd0, imem_addr}, 32'd2);
      req(4'b1000, 1'b1, 5'd6, 5'd7, 5'd0, 12'd3, 1'b0);    // srai x6,x7,3
      step();
      check("srai_word", imem_wdata, 32'h4033D313);
      check("srai_addr", {24'd0, imem_addr}, 32'd3);
      check("count_3", {23'd0, count}, 32'd3);

      in_valid = 1'b0;
      imem_ready = 1'b0;
      #1 check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_we", {31'd0, imem_we}, 32'd1);
         check("stall_word", imem_wdata, 32'h4033D313);
         check("stall_addr", {24'd0, imem_addr}, 32'd3);
         check("stall_count", {23'd0, count}, 32'd3);
      end
      imem_ready = 1'b1;
      step();
      check("drained_we", {31'd0, imem_we}, 32'd0);
      check("drained_count", {23'd0, count}, 32'd4);

      req(4'b1100, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0, 1'b0);    // illegal opcode
      step();
      check("illegal_err", {31'd0, err}, 32'd1);
      check("illegal_no_we", {31'd0, imem_we}, 32'd0);
      req(4'b0000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);    // add, last
      step();
      check("after_illegal_addr", {24'd0, imem_addr}, 32'd4);
      check("after_illegal_word", imem_wdata, 32'h002081B3);
      in_valid = 1'b0;
      in_last = 1'b0;
      check("drain_in_ready", {31'd0, in_ready}, 32'd0);
      check("drain_not_done", {31'd0, done}, 32'd0);
      step();
      check("done_set", {31'd0, done}, 32'd1);
      check("done_count", {23'd0, count}, 32'd5);
      check("done_err_sticky", {31'd0, err}, 32'd1);

      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_err", {31'd0, err}, 32'd0);
      check("restart_count", {23'd0, count}, 32'd0);
      check("restart_done", {31'd0, done}, 32'd0);
      req(4'b0001, 1'b1, 5'd3, 5'd1, 5'd0, 12'd1, 1'b0);    // sub with imm: illegal
      step();
      check("subi_err", {31'd0, err}, 32'd1);
      check("subi_no_we", {31'd0, imem_we}, 32'd0);
      imem_ready = 1'b0;
      req(4'b0100, 1'b0, 5'd4, 5'd5, 5'd6, 12'd0, 1'b0);    // xor x4,x5,x6
      step();
      in_valid = 1'b0;
      check("xor_word", imem_wdata, 32'h0062C233);
      check("xor_addr", {24'd0, imem_addr}, 32'd0);
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_we", {31'd0, imem_we}, 32'd0);
      check("midrst_wdata", imem_wdata, 32'd0);
      check("midrst_addr", {24'd0, imem_addr}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      imem_ready = 1'b1;
      step();
      rst_n = 1'b1;

      // Address-limit path on the 2-bit instance.
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("small_we", {31'd0, s_we}, 32'd1);
         check("small_addr", {30'd0, s_addr}, i);
      end
      check("small_full_in_ready", {31'd0, s_in_ready}, 32'd0);
      step();
      check("small_done", {31'd0, s_done}, 32'd1);
      check("small_count", {29'd0, s_count}, 32'd4);
      check("small_we_off", {31'd0, s_we}, 32'd0);
      step();
      check("small_5th_rejected", {29'd0, s_count}, 32'd4);
      check("small_done_ready", {31'd0, s_in_ready}, 32'd0);
      check("small_err", {31'd0, s_err}, 32'd0);
      s_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
